// File: rtl/s2p_ram_writer_pkg.sv
// Shared defaults for the serial-to-parallel RAM writer slice.
// Pure constants; no logic, no latency, no flow control.
package s2p_ram_writer_pkg;

  localparam int unsigned S2P_DEF_DATA_WIDTH = 8;
  localparam int unsigned S2P_DEF_ADDR_WIDTH = 4;

endpackage

// File: rtl/s2p_shifter.sv
// Serial bit assembler: word_done/word are combinational on the completing accepted bit.
// No backpressure of its own; the parent gates bit_acc and reads last_bit to decide.
module s2p_shifter
  import s2p_ram_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = S2P_DEF_DATA_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ser_in,
  input  logic                  bit_acc,
  input  logic                  ser_sync,
  output logic                  last_bit,
  output logic                  word_done,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_base;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_base;

  always_comb begin
    // A resync takes effect before a bit accepted in the same cycle.
    sr_base   = ser_sync ? '0 : sr_q;
    cnt_base  = ser_sync ? '0 : cnt_q;
    sr_d      = sr_base;
    cnt_d     = cnt_base;
    word_done = 1'b0;
    if (bit_acc) begin
      if (MSB_FIRST) begin
        sr_d = (sr_base << 1) | DATA_WIDTH'(ser_in);
      end else begin
        sr_d = (sr_base >> 1) | (DATA_WIDTH'(ser_in) << (DATA_WIDTH - 1));
      end
      if (cnt_base == LAST_CNT) begin
        word_done = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  assign word     = sr_d;
  assign last_bit = (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/s2p_ram_writer.sv
// Serial-to-parallel RAM writer with FIFO pointers; word written one cycle after its last bit, visible the next edge.
// ser_ready drops on a word's last bit when the RAM (counting the in-flight write) is full.
module s2p_ram_writer
  import s2p_ram_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = S2P_DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = S2P_DEF_ADDR_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ser_in,
  input  logic                  ser_valid,
  output logic                  ser_ready,
  input  logic                  ser_sync,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [DATA_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH+1:0] occ;
  logic                  last_bit, word_done, bit_acc, pop;
  logic [DATA_WIDTH-1:0] word;

  s2p_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .ser_in    (ser_in),
    .bit_acc   (bit_acc),
    .ser_sync  (ser_sync),
    .last_bit  (last_bit),
    .word_done (word_done),
    .word      (word)
  );

  always_comb begin
    // The write already registered but not yet counted still claims a slot.
    occ       = {1'b0, count_q} + (ADDR_WIDTH + 2)'(we_q);
    ser_ready = !(last_bit && (occ >= (ADDR_WIDTH + 2)'(DEPTH)));
    bit_acc   = ser_valid & ser_ready;
    pop       = (count_q != '0) & rd_ready;
    we_d      = word_done;
    din_d     = word_done ? word : din_q;
    wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(we_q);
    rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(pop);
    count_d   = count_q + (ADDR_WIDTH + 1)'(we_q) - (ADDR_WIDTH + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      din_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      we_q     <= we_d;
      din_q    <= din_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign we       = we_q;
  assign din      = din_q;
  assign addr_wr  = wr_ptr_q;
  assign addr_rd  = rd_ptr_q;
  assign count    = count_q;
  assign rd_valid = (count_q != '0);
  assign full     = (count_q == (ADDR_WIDTH + 1)'(DEPTH));

endmodule

// File: tb/tb_s2p_ram_writer.sv
// Bench for s2p_ram_writer: directed table, corner sequences and randomized traffic against a word-queue model.
module tb_s2p_ram_writer;

  logic       clk = 1'b0;
  logic       reset, ser_in, ser_valid, ser_sync, rd_ready;
  logic       ser_ready, we, rd_valid, full;
  logic [3:0] addr_wr, addr_rd;
  logic [7:0] din;
  logic [4:0] count;

  logic       l_ser_in, l_ser_valid, l_ser_sync, l_rd_ready;
  logic       l_ser_ready, l_we, l_rd_valid, l_full;
  logic [3:0] l_addr_wr, l_addr_rd;
  logic [7:0] l_din;
  logic [4:0] l_count;

  always #5 clk = ~clk;

  s2p_ram_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_sync(ser_sync), .we(we), .addr_wr(addr_wr), .din(din), .addr_rd(addr_rd),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count), .full(full));

  s2p_ram_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .ser_in(l_ser_in), .ser_valid(l_ser_valid), .ser_ready(l_ser_ready),
    .ser_sync(l_ser_sync), .we(l_we), .addr_wr(l_addr_wr), .din(l_din), .addr_rd(l_addr_rd),
    .rd_valid(l_rd_valid), .rd_ready(l_rd_ready), .count(l_count), .full(l_full));

  // RAM stand-in next to the writer.
  logic [7:0] mem [0:15];
  always @(posedge clk) if (we) mem[addr_wr] <= din;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: partial bits, one pending write, queue of committed words.
  bit         m_bits[$];
  logic [7:0] m_fifo[$];
  bit         m_pend;
  logic [7:0] m_pend_w;
  int         m_wr, m_rd;

  function automatic bit m_ready();
    return !(m_bits.size() == 7 && (m_fifo.size() + int'(m_pend)) >= 16);
  endfunction

  task automatic m_clear();
    m_bits.delete(); m_fifo.delete(); m_pend = 0; m_pend_w = '0; m_wr = 0; m_rd = 0;
  endtask

  task automatic m_update(input bit r, input bit sv, input bit si, input bit sy, input bit rr);
    bit acc;
    if (r) begin
      m_clear();
      return;
    end
    acc = sv && m_ready();
    if (m_fifo.size() != 0 && rr) begin
      void'(m_fifo.pop_front());
      m_rd = (m_rd + 1) % 16;
    end
    if (m_pend) begin
      m_fifo.push_back(m_pend_w);
      m_wr = (m_wr + 1) % 16;
    end
    m_pend = 0;
    if (sy) m_bits.delete();
    if (acc) m_bits.push_back(si);
    if (m_bits.size() == 8) begin
      for (int i = 0; i < 8; i++) m_pend_w[7-i] = m_bits[i];
      m_pend = 1;
      m_bits.delete();
    end
  endtask

  task automatic m_check();
    chk("ser_ready", ser_ready, m_ready());
    chk("we", we, m_pend);
    if (m_pend) begin
      chk("din", din, m_pend_w);
      chk("addr_wr", addr_wr, m_wr);
    end
    chk("rd_valid", rd_valid, m_fifo.size() != 0);
    chk("count", count, m_fifo.size());
    chk("full", full, m_fifo.size() == 16);
    chk("addr_rd", addr_rd, m_rd);
    if (m_fifo.size() != 0) chk("head_word", mem[addr_rd], m_fifo[0]);
  endtask

  task automatic drive(input bit r, input bit sv, input bit si, input bit sy, input bit rr);
    reset = r; ser_valid = sv; ser_in = si; ser_sync = sy; rd_ready = rr;
  endtask

  task automatic cyc(input bit r, input bit sv, input bit si, input bit sy, input bit rr);
    drive(r, sv, si, sy, rr);
    @(negedge clk);
    m_check();
    @(posedge clk);
    m_update(r, sv, si, sy, rr);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0);
    l_ser_valid = 0; l_ser_in = 0; l_ser_sync = 0; l_rd_ready = 0;
    repeat (2) @(posedge clk);
    m_clear();
    #1;
    reset = 0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit rr);
    for (int i = 7; i >= 0; i--) cyc(0, 1, w[i], 0, rr);
  endtask

  typedef struct {
    bit sv; bit si; bit sy; bit rr;
    bit e_rdy; bit e_we; logic [7:0] e_din; logic [3:0] e_aw;
    bit e_rdv; logic [4:0] e_cnt; logic [7:0] e_head;
  } vec_t;

  function automatic vec_t mk(bit sv, bit si, bit sy, bit rr, bit e_rdy, bit e_we,
                              logic [7:0] e_din, logic [3:0] e_aw, bit e_rdv,
                              logic [4:0] e_cnt, logic [7:0] e_head);
    vec_t v;
    v.sv = sv; v.si = si; v.sy = sy; v.rr = rr; v.e_rdy = e_rdy; v.e_we = e_we;
    v.e_din = e_din; v.e_aw = e_aw; v.e_rdv = e_rdv; v.e_cnt = e_cnt; v.e_head = e_head;
    return v;
  endfunction

  vec_t       tbl[$];
  logic [7:0] b;
  logic [7:0] w17;

  initial begin
    // Directed table: 0xA5 stream and pop, then 3 stray bits, resync, 0x3C.
    b = 8'hA5;
    for (int i = 7; i >= 0; i--) tbl.push_back(mk(1, b[i], 0, 0, 1, 0, 8'h00, 4'h0, 0, 5'd0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 8'hA5, 4'h0, 0, 5'd0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 4'h0, 1, 5'd1, 8'hA5));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'h00, 4'h0, 1, 5'd1, 8'hA5));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 4'h0, 0, 5'd0, 8'h00));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 0, 1, 0, 8'h00, 4'h0, 0, 5'd0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 8'h00, 4'h0, 0, 5'd0, 8'h00));
    b = 8'h3C;
    for (int i = 7; i >= 0; i--) tbl.push_back(mk(1, b[i], 0, 0, 1, 0, 8'h00, 4'h0, 0, 5'd0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 8'h3C, 4'h1, 0, 5'd0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 4'h0, 1, 5'd1, 8'h3C));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'h00, 4'h0, 1, 5'd1, 8'h3C));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 4'h0, 0, 5'd0, 8'h00));

    do_reset();
    chk("rst_ser_ready", ser_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_we", we, 0);
    chk("rst_din", din, 0);
    chk("rst_addr_wr", addr_wr, 0);
    chk("rst_addr_rd", addr_rd, 0);

    foreach (tbl[k]) begin
      drive(0, tbl[k].sv, tbl[k].si, tbl[k].sy, tbl[k].rr);
      @(negedge clk);
      m_check();
      chk("tbl_ready", ser_ready, tbl[k].e_rdy);
      chk("tbl_we", we, tbl[k].e_we);
      if (tbl[k].e_we) begin
        chk("tbl_din", din, tbl[k].e_din);
        chk("tbl_addr_wr", addr_wr, tbl[k].e_aw);
      end
      chk("tbl_rd_valid", rd_valid, tbl[k].e_rdv);
      chk("tbl_count", count, tbl[k].e_cnt);
      if (tbl[k].e_rdv) chk("tbl_head", mem[addr_rd], tbl[k].e_head);
      @(posedge clk);
      m_update(0, tbl[k].sv, tbl[k].si, tbl[k].sy, tbl[k].rr);
      #1;
    end

    // LSB-first instance: 1,0,0,0,0,0,0,0 assembles to 0x01.
    for (int i = 0; i < 8; i++) begin
      l_ser_valid = 1; l_ser_in = (i == 0);
      cyc(0, 0, 0, 0, 0);
    end
    l_ser_valid = 0; l_ser_in = 0;
    for (int k = 0; k < 4 && !l_we; k++) cyc(0, 0, 0, 0, 0);
    chk("lsb_we_seen", l_we, 1);
    chk("lsb_din", l_din, 8'h01);
    chk("lsb_addr_wr", l_addr_wr, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lsb_count", l_count, 1);

    // Fill to DEPTH, stall on word 17's last bit, pop once, wrap write to slot 0.
    do_reset();
    for (int w = 0; w < 16; w++) send_word(8'($urandom), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    w17 = 8'($urandom);
    for (int i = 7; i >= 1; i--) cyc(0, 1, w17[i], 0, 0);
    chk("fill_ready_low", ser_ready, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, w17[0], 0, 0);
    chk("fill_no_write", we, 0);
    cyc(0, 1, w17[0], 0, 1);
    cyc(0, 1, w17[0], 0, 0);
    chk("wrap_we", we, 1);
    chk("wrap_addr_wr", addr_wr, 0);
    chk("wrap_din", din, w17);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1);
    chk("drain_count", count, 0);

    // Write and pop in the same cycle at count 5.
    do_reset();
    for (int w = 0; w < 5; w++) send_word(8'($urandom), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("c5_count", count, 5);
    send_word(8'($urandom), 0);
    chk("c5_we_now", we, 1);
    cyc(0, 0, 0, 0, 1);
    chk("c5_count_held", count, 5);
    chk("c5_rd_ptr", addr_rd, 1);
    chk("c5_wr_ptr", addr_wr, 6);

    // Reset mid-word, then reset while a write is pending.
    do_reset();
    send_word(8'h5A, 0);
    send_word(8'hC3, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, i[0], 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk("rmw_ready", ser_ready, 1);
    chk("rmw_rd_valid", rd_valid, 0);
    chk("rmw_count", count, 0);
    chk("rmw_addr_wr", addr_wr, 0);
    chk("rmw_addr_rd", addr_rd, 0);
    send_word(8'h96, 0);
    chk("rpw_we_pending", we, 1);
    cyc(1, 0, 0, 0, 0);
    chk("rpw_we", we, 0);
    chk("rpw_din", din, 0);
    chk("rpw_count", count, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    chk("rpw_still_empty", rd_valid, 0);

    // Randomized traffic with alternating drain pressure, resyncs and rare resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit rr;
      rr = ((c / 300) % 2 == 1) ? ($urandom_range(7) == 0) : ($urandom_range(3) != 0);
      cyc($urandom_range(699) == 0, $urandom_range(4) != 0, 1'($urandom),
          $urandom_range(49) == 0, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
